assoc_cache_controller: RTL and testbench
=========================================

# assoc_cache_controller

Two-way set-associative, write-through, read-allocate cache controller placed between the MEM stage and the SRAM controller. It is the parametrised successor of the direct-mapped controller. Line width, set count and data width are configurable, and it adds LRU replacement, write-update on hit, a bulk flush, and read hit/miss counters. Tag/valid/data/LRU arrays are internal registers.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width (multiple of 8)
- LINE_WORDS, 2, words per line (power of 2, ≥2)
- SETS, 64, sets per way (power of 2, ≥2)
- CNT_W, 16, hit/miss counter width

Address split, LSB first:
- byte offset: log2(DATA_W/8) bits
- word offset: log2(LINE_WORDS) bits
- index: log2(SETS) bits
- tag: remaining bits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  request byte address
- write_data  in  DATA_W  store data
- mem_read_en  in  1  load request
- mem_write_en  in  1  store request
- flush  in  1  invalidate entire cache
- read_data  out  DATA_W  load result, valid when ready=1 on a load
- ready  out  1  request completes this cycle; 0 stalls the pipeline
- sram_addr  out  ADDR_W  SRAM address
- sram_write_data  out  DATA_W  SRAM store data
- sram_read_data  in  LINE_WORDS*DATA_W  full line; word k at bits [k*DATA_W +: DATA_W]
- sram_read_en  out  1  line fetch request
- sram_write_en  out  1  word store request
- sram_ready  in  1  SRAM transaction done (single-cycle pulse)
- hit_count  out  CNT_W  read hits, saturating
- miss_count  out  CNT_W  read misses, saturating

## Operation
State machine has three states: IDLE, MISS, WRITE.

IDLE behaviour, evaluated in this priority order:
- **flush:** clears all valid and LRU bits at the next edge. ready=0 that cycle; the request is ignored and the master holds it.
- **mem_write_en** (wins over mem_read_en if both are set):
  - On a tag hit, the addressed word in the hit way is updated at the edge and LRU marks that way as most recent.
  - No allocate on a miss.
  - Go to WRITE.
- **mem_read_en, hit:** read_data = addressed word, ready=1. LRU marks the hit way as most recent. hit_count increments.
- **mem_read_en, miss:** go to MISS. miss_count increments at this edge.
- **No request:** ready=1, read_data=0.

MISS:
- sram_read_en=1; sram_addr = addr with word and byte offsets zeroed.
- On sram_ready:
  - Victim way: first invalid way, way 0 preferred; otherwise the LRU way.
  - Write the line, tag and valid into the victim; LRU marks the victim as most recent.
  - read_data = word from sram_read_data; ready=1; go to IDLE.

WRITE:
- sram_write_en=1, sram_addr=addr, sram_write_data=write_data.
- On sram_ready: ready=1, go to IDLE.

Outputs:
- sram_* outputs are 0 outside their state.
- read_data=0 except during a read-hit cycle or the MISS completion cycle.
- flush is ignored outside IDLE.

Counters:
- Saturate at all-ones.
- Cleared only by rst, not by flush.

Requester contract:
- Holds addr, write_data and the enables stable until ready=1.
- A hit on the same edge as a fill cannot occur because requests are serialised.

## Timing
- Read hit: 0 wait cycles; ready and read_data are combinational in the request cycle.
- Read miss: one IDLE cycle with ready=0, then MISS until sram_ready. Data is returned and ready=1 in the sram_ready cycle.
- Write: one IDLE cycle with ready=0, then WRITE until sram_ready.
- Reset (also mid-MISS or mid-WRITE), at the next edge:
  - state=IDLE; all valid and LRU bits=0; counters=0.
  - sram_read_en=0, sram_write_en=0, sram_addr=0, sram_write_data=0, read_data=0.
  - ready=1 while idle.
  - An in-flight fill is discarded.

## Test plan
Default parameters: index = addr[8:3], word select = addr[2].
- **Fill and hit:** rst, then read 0x104; SRAM returns {0xBBBBBBBB, 0xAAAAAAAA}.
  - Expect sram_addr=0x100 and read_data=0xBBBBBBBB in the sram_ready cycle.
  - Then read 0x100: hit in the same cycle, read_data=0xAAAAAAAA, sram_read_en stays 0, hit_count=1, miss_count=1.
- **LRU:** read 0x100, then 0x300, then 0x100 (hit), then 0x500 (evicts 0x300). Then read 0x100 → hit; read 0x300 → miss.
- **Write-update:** after filling 0x100, write 0x104 with 0x12345678.
  - Expect sram_write_en with sram_addr=0x104 and sram_write_data=0x12345678.
  - Then read 0x104: hit returning 0x12345678, no SRAM read.
- **Write miss, no allocate:** write 0x700, then read 0x700 → miss; miss_count increments.
- **Flush:** fill 0x100 and 0x300, pulse flush in IDLE (ready=0 that cycle). Then read 0x100 → miss; counters are preserved.
- **Reset mid-miss:** rst while in MISS before sram_ready. Next cycle: sram_read_en=0, ready=1, counters=0; a read of any previously filled line misses.

Source files
------------

// File: rtl/assoc_cache_controller.sv
// Two-way set-associative, write-through, read-allocate cache between the MEM stage
// and the SRAM controller, with per-set LRU, write-update on hit, flush and hit/miss counters.
module assoc_cache_controller #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int SETS       = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         mem_read_en,
  input  logic                         mem_write_en,
  input  logic                         flush,
  output logic [DATA_W-1:0]            read_data,
  output logic                         ready,
  output logic [ADDR_W-1:0]            sram_addr,
  output logic [DATA_W-1:0]            sram_write_data,
  input  logic [LINE_WORDS*DATA_W-1:0] sram_read_data,
  output logic                         sram_read_en,
  output logic                         sram_write_en,
  input  logic                         sram_ready,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = BYTE_W + WORD_W;
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [WORD_W-1:0] sel);
    word_sel = line[int'(sel)*DATA_W +: DATA_W];
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SETS-1:0]     r_valid [2];
  logic [SETS-1:0]     r_lru;
  logic [TAG_W-1:0]    r_tag   [2][SETS];
  logic [LINE_W-1:0]   r_data  [2][SETS];
  logic [CNT_W-1:0]    r_hit_count;
  logic [CNT_W-1:0]    r_miss_count;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [WORD_W-1:0]   w_word;
  logic [ADDR_W-1:0]   w_line_addr;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic [DATA_W-1:0]   w_hit_word;
  logic                w_do_flush;
  logic                w_do_wupd;
  logic                w_do_hit;
  logic                w_do_miss;
  logic                w_do_fill;

  assign w_idx       = addr[OFF_W +: IDX_W];
  assign w_tag       = addr[ADDR_W-1 -: TAG_W];
  assign w_word      = addr[BYTE_W +: WORD_W];
  assign w_line_addr = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_hit0      = r_valid[1'b0][w_idx] && (r_tag[1'b0][w_idx] == w_tag);
  assign w_hit1      = r_valid[1'b1][w_idx] && (r_tag[1'b1][w_idx] == w_tag);
  assign w_hit       = w_hit0 || w_hit1;
  assign w_hit_way   = w_hit1;
  assign w_hit_word  = word_sel(r_data[w_hit_way][w_idx], w_word);
  // Fill the first invalid way (way 0 first), else the least recently used one.
  assign w_victim    = !r_valid[1'b0][w_idx] ? 1'b0 :
                       (!r_valid[1'b1][w_idx] ? 1'b1 : r_lru[w_idx]);
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

  // Next-state, handshake outputs and array-update strobes.
  always_comb begin
    w_state_nxt     = r_state;
    ready           = 1'b0;
    read_data       = {DATA_W{1'b0}};
    sram_addr       = {ADDR_W{1'b0}};
    sram_write_data = {DATA_W{1'b0}};
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    w_do_flush      = 1'b0;
    w_do_wupd       = 1'b0;
    w_do_hit        = 1'b0;
    w_do_miss       = 1'b0;
    w_do_fill       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_do_flush = 1'b1;
        end else if (mem_write_en) begin
          w_do_wupd   = w_hit;
          w_state_nxt = S_WRITE;
        end else if (mem_read_en) begin
          if (w_hit) begin
            ready     = 1'b1;
            read_data = w_hit_word;
            w_do_hit  = 1'b1;
          end else begin
            w_do_miss   = 1'b1;
            w_state_nxt = S_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_MISS: begin
        sram_read_en = 1'b1;
        sram_addr    = w_line_addr;
        if (sram_ready) begin
          w_do_fill   = 1'b1;
          ready       = 1'b1;
          read_data   = word_sel(sram_read_data, w_word);
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_MISS;
        end
      end
      S_WRITE: begin
        sram_write_en   = 1'b1;
        sram_addr       = addr;
        sram_write_data = write_data;
        if (sram_ready) begin
          ready       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, valid/LRU bits and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid[0]   <= {SETS{1'b0}};
      r_valid[1]   <= {SETS{1'b0}};
      r_lru        <= {SETS{1'b0}};
      r_hit_count  <= {CNT_W{1'b0}};
      r_miss_count <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_do_flush) begin
        r_valid[0] <= {SETS{1'b0}};
        r_valid[1] <= {SETS{1'b0}};
        r_lru      <= {SETS{1'b0}};
      end
      if (w_do_wupd || w_do_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
      end
      if (w_do_hit && (r_hit_count != CNT_MAX)) begin
        r_hit_count <= r_hit_count + CNT_ONE;
      end
      if (w_do_miss && (r_miss_count != CNT_MAX)) begin
        r_miss_count <= r_miss_count + CNT_ONE;
      end
      if (w_do_fill) begin
        r_valid[w_victim][w_idx] <= 1'b1;
        r_lru[w_idx]             <= ~w_victim;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_do_wupd) begin
        r_data[w_hit_way][w_idx][int'(w_word)*DATA_W +: DATA_W] <= write_data;
      end
      if (w_do_fill) begin
        r_tag[w_victim][w_idx]  <= w_tag;
        r_data[w_victim][w_idx] <= sram_read_data;
      end
    end
  end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Scoreboard bench for assoc_cache_controller: the driver queues hand-computed responses,
// a monitor pops and compares them whenever a request completes.
module tb_assoc_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] read_data;
  logic        ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_read_en;
  logic        sram_write_en;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  typedef struct {
    logic [31:0] data;
    int          kind;   // 0 hit, 1 miss fill, 2 write-through
    logic [31:0] sa;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sram_block = 1'b0;
  int   sram_lat = 1;
  int   wait_cnt = 0;

  always #5 clk = ~clk;

  assoc_cache_controller dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .flush(flush),
    .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  function automatic logic [63:0] sram_line(input logic [31:0] a);
    case (a)
      32'h100: sram_line = {32'hBBBBBBBB, 32'hAAAAAAAA};
      32'h300: sram_line = {32'h33331111, 32'h33330000};
      32'h500: sram_line = {32'h55551111, 32'h55550000};
      32'h700: sram_line = {32'h77771111, 32'h77770000};
      default: sram_line = {32'hDEADBEEF, 32'hDEADBEEF};
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // SRAM model: answers a pending transaction after sram_lat waiting cycles.
  initial begin
    sram_ready = 1'b0;
    sram_read_data = 64'h0;
    forever begin
      @(negedge clk);
      if (sram_ready) begin
        sram_ready = 1'b0;
        wait_cnt = 0;
      end else if ((sram_read_en || sram_write_en) && !sram_block) begin
        if (wait_cnt >= sram_lat) begin
          sram_ready = 1'b1;
          sram_read_data = sram_line(sram_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every completed request is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ready && (mem_read_en || mem_write_en)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got completion at addr %h want none", addr);
        end else begin
          e = sb_q.pop_front();
          check32("read_data", read_data, e.data);
          check32("sram_addr", sram_addr, e.sa);
          check32("sram_write_data", sram_write_data, e.wd);
          check32("sram_read_en", {31'd0, sram_read_en}, (e.kind == 1) ? 32'd1 : 32'd0);
          check32("sram_write_en", {31'd0, sram_write_en}, (e.kind == 2) ? 32'd1 : 32'd0);
        end
      end
    end
  end

  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_data, input int kind, input logic [31:0] exp_sa);
    exp_t e;
    int   cyc;
    bit   done;
    e.data = exp_data;
    e.kind = kind;
    e.sa   = exp_sa;
    e.wd   = (kind == 2) ? wd : 32'h0;
    sb_q.push_back(e);
    addr = a;
    write_data = wd;
    mem_write_en = wr;
    mem_read_en = !wr;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      #2;
      if (ready) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready for addr %h want completion", a);
      void'(sb_q.pop_back());
    end else begin
      check32("latency", cyc, (kind == 0) ? 32'd0 : 32'd2);
    end
    @(negedge clk);
    mem_read_en = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input int kind, input logic [31:0] sa);
    req(1'b0, a, 32'h0, d, kind, sa);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int h, input int m);
    check32({tag, "_hit_count"}, {16'd0, hit_count}, h);
    check32({tag, "_miss_count"}, {16'd0, miss_count}, m);
  endtask

  initial begin
    do_reset();
    #2;
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_read_data", read_data, 32'h0);
    check32("rst_sram_addr", sram_addr, 32'h0);
    check32("rst_sram_en", {30'd0, sram_read_en, sram_write_en}, 32'd0);
    check_counts("rst", 0, 0);
    @(negedge clk);

    // Fill and hit
    rd(32'h104, 32'hBBBBBBBB, 1, 32'h100);
    rd(32'h100, 32'hAAAAAAAA, 0, 32'h0);
    check_counts("fill", 1, 1);

    // LRU replacement within set 0x20
    do_reset();
    rd(32'h100, 32'hAAAAAAAA, 1, 32'h100);
    rd(32'h300, 32'h33330000, 1, 32'h300);
    rd(32'h100, 32'hAAAAAAAA, 0, 32'h0);
    rd(32'h500, 32'h55550000, 1, 32'h500);
    rd(32'h100, 32'hAAAAAAAA, 0, 32'h0);
    rd(32'h300, 32'h33330000, 1, 32'h300);
    check_counts("lru", 2, 4);

    // Write-update on hit, then write miss without allocate
    req(1'b1, 32'h104, 32'h12345678, 32'h0, 2, 32'h104);
    rd(32'h104, 32'h12345678, 0, 32'h0);
    rd(32'h100, 32'hAAAAAAAA, 0, 32'h0);
    check_counts("wupd", 4, 4);
    req(1'b1, 32'h700, 32'hCAFEF00D, 32'h0, 2, 32'h700);
    rd(32'h700, 32'h77770000, 1, 32'h700);
    rd(32'h104, 32'h12345678, 0, 32'h0);
    check_counts("wmiss", 5, 5);

    // Flush with a read held on the bus
    do_reset();
    rd(32'h100, 32'hAAAAAAAA, 1, 32'h100);
    rd(32'h300, 32'h33330000, 1, 32'h300);
    rd(32'h100, 32'hAAAAAAAA, 0, 32'h0);
    addr = 32'h100;
    mem_read_en = 1'b1;
    flush = 1'b1;
    #2;
    check32("flush_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    mem_read_en = 1'b0;
    check_counts("flush", 1, 2);
    rd(32'h100, 32'hAAAAAAAA, 1, 32'h100);
    rd(32'h304, 32'h33331111, 1, 32'h300);
    check_counts("postflush", 1, 4);

    // Reset in the middle of a miss
    sram_block = 1'b1;
    addr = 32'h500;
    mem_read_en = 1'b1;
    @(negedge clk);
    #2;
    check32("midmiss_sram_read_en", {31'd0, sram_read_en}, 32'd1);
    check32("midmiss_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sram_block = 1'b0;
    #2;
    check32("postrst_sram_read_en", {31'd0, sram_read_en}, 32'd0);
    check32("postrst_ready", {31'd0, ready}, 32'd1);
    check32("postrst_sram_addr", sram_addr, 32'h0);
    check_counts("postrst", 0, 0);
    @(negedge clk);
    rd(32'h100, 32'hAAAAAAAA, 1, 32'h100);
    check_counts("final", 0, 1);

    repeat (3) @(negedge clk);
    check32("scoreboard_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
